// File: rtl/preg_free_list_pkg.sv
// Shared rename constants and the physical-tag type, also used by the ROB and rename table.
package preg_free_list_pkg;

   localparam int PHYS_REGS = 64;
   localparam int ARCH_REGS = 32;
   localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
   localparam int PTR_WIDTH = $clog2(DEPTH) + 1;
   localparam int TAG_WIDTH = $clog2(PHYS_REGS);

   typedef logic [TAG_WIDTH-1:0] preg_t;
   typedef logic [PTR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit side of the physical register free list.
interface preg_free_list_if;
   import preg_free_list_pkg::*;

   logic  alloc_req;
   logic  alloc_ready;
   preg_t alloc_preg;
   logic  free_en;
   preg_t free_preg;
   logic  commit_en;
   logic  flush;
   ptr_t  free_count;

   modport master (
      output alloc_req, free_en, free_preg, commit_en, flush,
      input  alloc_ready, alloc_preg, free_count
   );

   modport slave (
      input  alloc_req, free_en, free_preg, commit_en, flush,
      output alloc_ready, alloc_preg, free_count
   );

endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical tags: alloc at the speculative head, return at the tail,
// and a retirement head that lets a mispredict flush restore the speculative head in one cycle.
module preg_free_list
   import preg_free_list_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   preg_free_list_if.slave   fl_if
);

   localparam int IDX_W = PTR_WIDTH - 1;

   preg_t r_mem [DEPTH];
   ptr_t  r_spec_head;
   ptr_t  r_ret_head;
   ptr_t  r_tail;

   logic  w_empty;
   logic  w_alloc;
   ptr_t  w_ret_head_nxt;
   ptr_t  w_spec_head_nxt;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

   // No bypass: emptiness comes from registered pointers, so a same-cycle free cannot feed an alloc.
   always_comb begin
      w_empty         = (r_spec_head == r_tail);
      w_alloc         = fl_if.alloc_req & ~w_empty & ~fl_if.flush;
      w_ret_head_nxt  = fl_if.commit_en ? ptr_inc(r_ret_head) : r_ret_head;
      w_spec_head_nxt = r_spec_head;
      if (fl_if.flush)
         w_spec_head_nxt = w_ret_head_nxt;
      else if (w_alloc)
         w_spec_head_nxt = ptr_inc(r_spec_head);
   end

   assign fl_if.alloc_ready = ~w_empty;
   assign fl_if.alloc_preg  = r_mem[r_spec_head[IDX_W-1:0]];
   assign fl_if.free_count  = r_tail - r_spec_head;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_spec_head <= '0;
         r_ret_head  <= '0;
         r_tail      <= ptr_t'(DEPTH);
      end else begin
         r_spec_head <= w_spec_head_nxt;
         r_ret_head  <= w_ret_head_nxt;
         if (fl_if.free_en)
            r_tail <= ptr_inc(r_tail);
      end
   end

   // Reset reloads every non-architectural tag so pre-reset returns are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= preg_t'(ARCH_REGS + i);
      end else if (fl_if.free_en) begin
         r_mem[r_tail[IDX_W-1:0]] <= fl_if.free_preg;
      end
   end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: the driver queues hand-computed expectations, a monitor checks them.
module tb_preg_free_list;
   import preg_free_list_pkg::*;

   localparam int PW = 1 << PTR_WIDTH;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   preg_free_list_if fl();

   preg_free_list dut (
      .clk   (clk),
      .rst   (rst),
      .fl_if (fl)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string nm;
      int    cyc;
      bit    rdy;
      bit    chkp;
      int    preg;
      int    cnt;
   } exp_t;

   exp_t q[$];

   // Protocol-only pointer tracking (overflow / underflow assertions on the stimulus).
   int m_spec, m_ret, m_tail;

   task automatic expect_next(input string nm, input bit rdy, input bit chkp,
                              input int preg, input int cnt);
      exp_t e;
      e.nm   = nm;
      e.cyc  = cyc + 1;
      e.rdy  = rdy;
      e.chkp = chkp;
      e.preg = preg;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic drive(input bit areq, input bit fen, input int fp,
                        input bit cen, input bit flsh, input bit rs = 1'b0);
      int ns, nr, nt;
      fl.alloc_req = areq;
      fl.free_en   = fen;
      fl.free_preg = preg_t'(fp);
      fl.commit_en = cen;
      fl.flush     = flsh;
      rst          = rs;
      if (rs) begin
         m_spec = 0;
         m_ret  = 0;
         m_tail = DEPTH;
      end else begin
         nr = cen ? (m_ret + 1) % PW : m_ret;
         nt = fen ? (m_tail + 1) % PW : m_tail;
         ns = flsh ? nr : ((areq && m_spec != m_tail) ? (m_spec + 1) % PW : m_spec);
         assert (((nt - nr + PW) % PW) <= DEPTH) else $error("protocol overflow: tail-ret_head exceeds DEPTH");
         assert (((ns - nr + PW) % PW) <= DEPTH) else $error("protocol underflow: ret_head passed spec_head");
         m_spec = ns;
         m_ret  = nr;
         m_tail = nt;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are continuous, so every queued expectation is checked mid-cycle.
   initial forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.nm, e.cyc, cyc);
         end else begin
            if (fl.alloc_ready !== e.rdy) begin
               errors++;
               $display("FAIL %s cyc %0d: alloc_ready got %0b want %0b", e.nm, cyc, fl.alloc_ready, e.rdy);
            end
            checks++;
            if (fl.free_count !== ptr_t'(e.cnt)) begin
               errors++;
               $display("FAIL %s cyc %0d: free_count got %0d want %0d", e.nm, cyc, fl.free_count, e.cnt);
            end
            if (e.chkp) begin
               checks++;
               if (fl.alloc_preg !== preg_t'(e.preg)) begin
                  errors++;
                  $display("FAIL %s cyc %0d: alloc_preg got %0d want %0d", e.nm, cyc, fl.alloc_preg, e.preg);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(0, 0, 0, 0, 0, 1);
      expect_next("reset", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 0, 1);

      // Drain the list: tags 32..63 in order, then empty.
      for (int k = 0; k < 32; k++) begin
         expect_next("alloc_seq", k < 31, k < 31, 33 + k, 31 - k);
         drive(1, 0, 0, 0, 0);
      end
      expect_next("alloc_empty", 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int k = 0; k < 32; k++) begin
         expect_next("commit_drain", 0, 0, 0, 0);
         drive(0, 0, 0, 1, 0);
      end

      // Free into empty list with a same-cycle alloc: alloc ignored, tag visible next cycle.
      expect_next("free_no_bypass", 1, 1, 5, 1);
      drive(1, 1, 5, 0, 0);
      expect_next("alloc_freed", 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0);

      // Alloc 4, commit 2, flush -> head back at tag 34.
      expect_next("rst_a", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         expect_next("alloc4", 1, 1, 33 + k, 31 - k);
         drive(1, 0, 0, 0, 0);
      end
      for (int k = 0; k < 2; k++) begin
         expect_next("commit_hold", 1, 1, 36, 28);
         drive(0, 0, 0, 1, 0);
      end
      expect_next("flush_restore", 1, 1, 34, 30);
      drive(0, 0, 0, 0, 1);

      // Alloc 3, commit 1, then commit+flush+alloc together -> spec_head = ret_head = 2.
      expect_next("rst_b", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         expect_next("alloc3", 1, 1, 33 + k, 31 - k);
         drive(1, 0, 0, 0, 0);
      end
      expect_next("commit_hold3", 1, 1, 35, 29);
      drive(0, 0, 0, 1, 0);
      expect_next("flush_commit", 1, 1, 34, 30);
      drive(1, 0, 0, 1, 1);

      // Wrap: drain, return 10..41, drain again across the pointer wrap.
      expect_next("rst_c", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 32; k++) begin
         expect_next("wrap_alloc1", k < 31, k < 31, 33 + k, 31 - k);
         drive(1, 0, 0, 1, 0);
      end
      for (int k = 0; k < 32; k++) begin
         expect_next("wrap_free", 1, 1, 10, k + 1);
         drive(0, 1, 10 + k, 0, 0);
      end
      for (int k = 0; k < 32; k++) begin
         expect_next("wrap_alloc2", k < 31, k < 31, 11 + k, 31 - k);
         drive(1, 0, 0, 1, 0);
      end

      // Partial alloc with pending frees, then reset mid-operation.
      expect_next("rst_d", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 7; k++) begin
         expect_next("partial_alloc", 1, 1, 33 + k, (k < 3) ? 32 : 31 - (k - 3));
         if (k < 3) drive(1, 1, 1 + k, 1, 0);
         else       drive(1, 0, 0, 0, 0);
      end
      expect_next("rst_mid", 1, 1, 32, 32);
      drive(1, 1, 7, 1, 1, 1);
      expect_next("flush_no_commit", 1, 1, 32, 32);
      drive(0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
         expect_next("post_rst_alloc", 1, 1, 33 + k, 31 - k);
         drive(1, 0, 0, 0, 0);
      end

      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
